// File: rtl/lcd_fifo_reader.sv
// LCD raster timing generator that drains RGB565 pixels from a show-ahead FIFO read port.
// Latency: rd_en is combinational; lcd_*, frame_start, uf_* are registered 1 cycle after the counter position.
// Backpressure: none toward the panel; a missing FIFO word (rd_vld=0) in active video emits UF_COLOR and counts underflow.
//
// Ports:
//   rd_clk, rd_rst        pixel clock, synchronous active-high reset
//   en                    display enable; sampled when idle and at the last position of a frame
//   clr_stat              clears uf_flag/uf_cnt (wins over a coincident underflow)
//   rd_vld, rd_data       FIFO head valid / head pixel
//   rd_en                 pop FIFO head on this edge
//   lcd_hs, lcd_vs        active-low syncs
//   lcd_de, lcd_rgb       data enable and pixel bus
//   frame_start           one-cycle pulse aligned with position (0,0) on the pins
//   uf_flag, uf_cnt       sticky underflow flag, saturating underflow pixel count
module lcd_fifo_reader #(
    parameter int          H_SYNC   = 41,
    parameter int          H_BP     = 2,
    parameter int          H_ACTIVE = 480,
    parameter int          H_FP     = 2,
    parameter int          V_SYNC   = 10,
    parameter int          V_BP     = 2,
    parameter int          V_ACTIVE = 272,
    parameter int          V_FP     = 2,
    parameter logic [15:0] UF_COLOR = 16'h0000
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic        en,
    input  logic        clr_stat,
    input  logic        rd_vld,
    input  logic [15:0] rd_data,
    output logic        rd_en,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [15:0] lcd_rgb,
    output logic        frame_start,
    output logic        uf_flag,
    output logic [15:0] uf_cnt
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
    localparam logic [10:0] V_ACT_BEG  = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_END  = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;

    logic        lcd_hs_q, lcd_hs_d;
    logic        lcd_vs_q, lcd_vs_d;
    logic        lcd_de_q, lcd_de_d;
    logic [15:0] lcd_rgb_q, lcd_rgb_d;
    logic        frame_start_q, frame_start_d;
    logic        uf_flag_q, uf_flag_d;
    logic [15:0] uf_cnt_q, uf_cnt_d;

    logic run;
    logic h_act;
    logic v_act;
    logic pix_act;
    logic starve;

    assign run     = (state_q == ST_RUN);
    assign h_act   = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    assign v_act   = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    assign pix_act = run && h_act && v_act;
    assign starve  = pix_act && !rd_vld;

    // Pop only when a word is actually present, so an empty FIFO is never read.
    assign rd_en   = pix_act && rd_vld;

    // Run control and raster counters. en is only honoured when idle or at the
    // last position, so a frame that has started always completes.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = '0;
                        if (!en) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        v_cnt_d = v_cnt_q + 11'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 11'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_cnt_d = '0;
                v_cnt_d = '0;
            end
        endcase
    end

    // Pin values for the current position; all registered together so the
    // syncs, DE and pixel bus stay aligned on the panel side.
    always_comb begin
        lcd_hs_d      = ~(run && (h_cnt_q < H_SYNC_END));
        lcd_vs_d      = ~(run && (v_cnt_q < V_SYNC_END));
        lcd_de_d      = pix_act;
        lcd_rgb_d     = '0;
        if (pix_act) begin
            lcd_rgb_d = rd_vld ? rd_data : UF_COLOR;
        end
        frame_start_d = run && (h_cnt_q == '0) && (v_cnt_q == '0);

        uf_flag_d = uf_flag_q;
        uf_cnt_d  = uf_cnt_q;
        if (clr_stat) begin
            uf_flag_d = 1'b0;
            uf_cnt_d  = '0;
        end else if (starve) begin
            uf_flag_d = 1'b1;
            if (uf_cnt_q != 16'hFFFF) begin
                uf_cnt_d = uf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            lcd_hs_q      <= 1'b1;
            lcd_vs_q      <= 1'b1;
            lcd_de_q      <= 1'b0;
            lcd_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            uf_flag_q     <= 1'b0;
            uf_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            lcd_hs_q      <= lcd_hs_d;
            lcd_vs_q      <= lcd_vs_d;
            lcd_de_q      <= lcd_de_d;
            lcd_rgb_q     <= lcd_rgb_d;
            frame_start_q <= frame_start_d;
            uf_flag_q     <= uf_flag_d;
            uf_cnt_q      <= uf_cnt_d;
        end
    end

    assign lcd_hs      = lcd_hs_q;
    assign lcd_vs      = lcd_vs_q;
    assign lcd_de      = lcd_de_q;
    assign lcd_rgb     = lcd_rgb_q;
    assign frame_start = frame_start_q;
    assign uf_flag     = uf_flag_q;
    assign uf_cnt      = uf_cnt_q;

endmodule

// File: tb/tb_lcd_fifo_reader.sv
// Bench for lcd_fifo_reader: a small-raster instance for timing/scoreboard checks,
// a wide-raster instance starved for underflow saturation, and a default-parameter
// instance for line/frame geometry.
module tb_lcd_fifo_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Small raster: H 4/2/8/2 (16), V 2/1/4/1 (8)
    logic        s_rst, s_en, s_clr, s_vld;
    logic [15:0] s_data;
    logic        s_rd_en, s_hs, s_vs, s_de, s_fs, s_uf;
    logic [15:0] s_rgb, s_cnt;

    // Wide raster, permanently starved: H 1/1/2044/1 (2047), V 1/1/40/1 (43)
    logic        g_rst, b_en, b_clr, b_vld;
    logic [15:0] b_data;
    logic        b_rd_en, b_hs, b_vs, b_de, b_fs, b_uf;
    logic [15:0] b_rgb, b_cnt;

    // Default parameters
    logic        d_en, d_clr, d_vld;
    logic [15:0] d_data;
    logic        d_rd_en, d_hs, d_vs, d_de, d_fs, d_uf;
    logic [15:0] d_rgb, d_cnt;

    lcd_fifo_reader #(
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_FP(2),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1)
    ) dut (
        .rd_clk(clk), .rd_rst(s_rst), .en(s_en), .clr_stat(s_clr),
        .rd_vld(s_vld), .rd_data(s_data), .rd_en(s_rd_en),
        .lcd_hs(s_hs), .lcd_vs(s_vs), .lcd_de(s_de), .lcd_rgb(s_rgb),
        .frame_start(s_fs), .uf_flag(s_uf), .uf_cnt(s_cnt)
    );

    lcd_fifo_reader #(
        .H_SYNC(1), .H_BP(1), .H_ACTIVE(2044), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(40), .V_FP(1),
        .UF_COLOR(16'hF800)
    ) dut_big (
        .rd_clk(clk), .rd_rst(g_rst), .en(b_en), .clr_stat(b_clr),
        .rd_vld(b_vld), .rd_data(b_data), .rd_en(b_rd_en),
        .lcd_hs(b_hs), .lcd_vs(b_vs), .lcd_de(b_de), .lcd_rgb(b_rgb),
        .frame_start(b_fs), .uf_flag(b_uf), .uf_cnt(b_cnt)
    );

    lcd_fifo_reader dut_def (
        .rd_clk(clk), .rd_rst(g_rst), .en(d_en), .clr_stat(d_clr),
        .rd_vld(d_vld), .rd_data(d_data), .rd_en(d_rd_en),
        .lcd_hs(d_hs), .lcd_vs(d_vs), .lcd_de(d_de), .lcd_rgb(d_rgb),
        .frame_start(d_fs), .uf_flag(d_uf), .uf_cnt(d_cnt)
    );

    // FIFO models and scoreboard state
    logic [15:0] s_head = 16'd0;
    logic [15:0] d_head = 16'd0;
    int          s_pops = 0;
    int          d_pops = 0;
    int          b_pops = 0;
    int          s_fs_cnt = 0;
    logic        s_rden_smp;
    logic [15:0] exp_q[$];

    typedef struct {
        int   p;
        logic hs;
        logic vs;
        logic de;
        logic fs;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string nm, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, actual, actual, expected, expected);
        end
    endtask

    // One pixel clock. Inputs set by the caller apply to the coming posedge;
    // rd_en is sampled before that edge, registered outputs after it.
    task automatic step();
        s_data = s_head;
        d_data = d_head;
        #1;
        s_rden_smp = s_rd_en;
        if (s_rd_en) begin s_head++; s_pops++; end
        if (d_rd_en) begin d_head++; d_pops++; end
        if (b_rd_en) b_pops++;
        @(negedge clk);
        #1;
        if (s_de) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pixel_extra: lcd_de high with nothing expected, lcd_rgb=0x%0h", s_rgb);
            end else begin
                chk("pixel", int'(s_rgb), int'(exp_q.pop_front()));
            end
        end
        if (s_fs) s_fs_cnt++;
    endtask

    task automatic chk_small_idle(input string nm);
        chk({nm, "_hs"}, int'(s_hs), 1);
        chk({nm, "_vs"}, int'(s_vs), 1);
        chk({nm, "_de"}, int'(s_de), 0);
        chk({nm, "_rgb"}, int'(s_rgb), 0);
        chk({nm, "_fs"}, int'(s_fs), 0);
    endtask

    initial begin
        int first_rd;
        int fs_before;
        int hs_len, de_len, vs_len, last_fall, d_first_rd;
        logic prev_hs, b_de_seen;

        // position, hs, vs, de, frame_start as seen on the pins for that position
        tbl[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{3,   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{31,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{53,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{54,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{61,  1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{62,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{102, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{118, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{127, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{128, 1'b0, 1'b0, 1'b0, 1'b1};

        // Expected pixels: frames 1-2 full, frame 3 starved on active pixels 10..12,
        // frame 4 full, then a restarted frame cut by reset.
        for (int i = 0; i < 64; i++) exp_q.push_back(16'(i));
        for (int i = 64; i < 74; i++) exp_q.push_back(16'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h0000);
        for (int i = 74; i < 125; i++) exp_q.push_back(16'(i));
        exp_q.push_back(16'd125);
        exp_q.push_back(16'd126);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'd127);

        s_rst = 1'b1; s_en = 1'b0; s_clr = 1'b0; s_vld = 1'b1; s_data = '0;
        g_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_vld = 1'b0; b_data = 16'hAAAA;
        d_en = 1'b0; d_clr = 1'b0; d_vld = 1'b1; d_data = '0;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();

        // Reset state
        chk_small_idle("reset");
        chk("reset_uf_flag", int'(s_uf), 0);
        chk("reset_uf_cnt", int'(s_cnt), 0);
        chk("reset_rd_en", int'(s_rden_smp), 0);
        chk("reset_big_uf_cnt", int'(b_cnt), 0);

        // Out of reset, en low: stays idle
        s_rst = 1'b0;
        g_rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_small_idle("idle_no_en");
        chk("idle_no_en_rd_en", int'(s_rden_smp), 0);

        // Start: en step, then positions p = 0..511 (four frames)
        s_en = 1'b1;
        step();
        chk("start_fs_not_yet", int'(s_fs), 0);
        s_fs_cnt = 0;
        s_pops = 0;
        first_rd = -1;
        for (int p = 0; p < 512; p++) begin
            s_vld = !(p >= 256 + 72 && p <= 256 + 74);
            s_en  = (p < 400);
            s_clr = (p == 390);
            step();
            if (s_rden_smp && first_rd < 0) first_rd = p;
            for (int i = 0; i < 14; i++) begin
                if (tbl[i].p == p) begin
                    chk($sformatf("tbl_hs_p%0d", p), int'(s_hs), int'(tbl[i].hs));
                    chk($sformatf("tbl_vs_p%0d", p), int'(s_vs), int'(tbl[i].vs));
                    chk($sformatf("tbl_de_p%0d", p), int'(s_de), int'(tbl[i].de));
                    chk($sformatf("tbl_fs_p%0d", p), int'(s_fs), int'(tbl[i].fs));
                end
            end
            if (p >= 256 + 72 && p <= 256 + 74) chk("starve_no_rd_en", int'(s_rden_smp), 0);
            if (p == 127) begin
                chk("frame1_pops", s_pops, 32);
                chk("frame1_fs_count", s_fs_cnt, 1);
                chk("first_rd_en_pos", first_rd, 54);
            end
            if (p == 255) begin
                chk("frame2_pops", s_pops, 64);
                chk("frame2_fs_count", s_fs_cnt, 2);
                chk("no_starve_uf_cnt", int'(s_cnt), 0);
                chk("no_starve_uf_flag", int'(s_uf), 0);
            end
            if (p == 389) begin
                chk("starve_uf_flag", int'(s_uf), 1);
                chk("starve_uf_cnt", int'(s_cnt), 3);
            end
            if (p == 390) begin
                chk("clr_uf_flag", int'(s_uf), 0);
                chk("clr_uf_cnt", int'(s_cnt), 0);
            end
            if (p == 511) begin
                chk("frame4_pops", s_pops, 125);
                chk("frame4_fs_count", s_fs_cnt, 4);
            end
        end

        // en was dropped mid frame 4: frame completed, now idle
        s_en = 1'b0;
        s_clr = 1'b0;
        s_vld = 1'b1;
        fs_before = s_fs_cnt;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("stop_idle_hs", int'(s_hs), 1);
            chk("stop_idle_de", int'(s_de), 0);
            chk("stop_idle_rd_en", int'(s_rden_smp), 0);
        end
        chk_small_idle("stop_idle");
        chk("stop_no_frame_start", s_fs_cnt, fs_before);

        // Restart, then reset during an active line
        s_en = 1'b1;
        step();
        chk("restart_fs_not_yet", int'(s_fs), 0);
        first_rd = -1;
        for (int p = 0; p < 59; p++) begin
            s_vld = (p != 56);
            s_rst = (p == 58);
            step();
            if (s_rden_smp && first_rd < 0) first_rd = p;
            if (p == 0) begin
                chk("restart_fs", int'(s_fs), 1);
                chk("restart_hs", int'(s_hs), 0);
                chk("restart_vs", int'(s_vs), 0);
            end
            if (p == 57) begin
                chk("pre_rst_uf_flag", int'(s_uf), 1);
                chk("pre_rst_uf_cnt", int'(s_cnt), 1);
                chk("pre_rst_de", int'(s_de), 1);
                chk("restart_first_rd_en", first_rd, 54);
            end
        end
        chk_small_idle("midreset");
        chk("midreset_uf_flag", int'(s_uf), 0);
        chk("midreset_uf_cnt", int'(s_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_reset_rd_en", int'(s_rden_smp), 0);
            chk("held_reset_de", int'(s_de), 0);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        s_en = 1'b0;
        s_rst = 1'b0;

        // Wide starved raster and default raster, started together
        b_en = 1'b1;
        d_en = 1'b1;
        step();
        hs_len = 0; de_len = 0; vs_len = 0; last_fall = -1; d_first_rd = -1;
        prev_hs = 1'b1;
        b_de_seen = 1'b0;
        for (int p = 0; p <= 76000; p++) begin
            b_clr = (p == 75999);
            step();
            if (d_rd_en === 1'b1 && d_first_rd < 0 && d_pops == 1) d_first_rd = p;
            if (p == 0) begin
                chk("def_frame_start", int'(d_fs), 1);
                chk("big_frame_start", int'(b_fs), 1);
            end
            if (b_de && !b_de_seen) begin
                b_de_seen = 1'b1;
                chk("big_uf_color", int'(b_rgb), 16'hF800);
            end
            if (p == 3 * 2047 + 1) begin
                chk("big_line_uf_cnt", int'(b_cnt), 2044);
                chk("big_line_uf_flag", int'(b_uf), 1);
            end
            if (p == 75998) begin
                chk("big_sat_uf_cnt", int'(b_cnt), 16'hFFFF);
                chk("big_sat_uf_flag", int'(b_uf), 1);
            end
            if (p == 75999) begin
                chk("big_clr_wins_cnt", int'(b_cnt), 0);
                chk("big_clr_wins_flag", int'(b_uf), 0);
            end
            if (p == 76000) begin
                chk("big_after_clr_cnt", int'(b_cnt), 1);
                chk("big_after_clr_flag", int'(b_uf), 1);
            end
            // Default raster geometry
            if (!d_hs && prev_hs) begin
                if (last_fall >= 0) chk("def_line_period", p - last_fall, 525);
                last_fall = p;
            end
            if (!d_hs) hs_len++;
            else if (hs_len != 0) begin
                chk("def_hs_width", hs_len, 41);
                hs_len = 0;
            end
            if (d_de) de_len++;
            else if (de_len != 0) begin
                chk("def_de_width", de_len, 480);
                de_len = 0;
            end
            if (!d_vs) vs_len++;
            else if (vs_len != 0) begin
                chk("def_vs_width", vs_len, 10 * 525);
                vs_len = 0;
            end
            prev_hs = d_hs;
            if (p == 144 * 525 - 1) chk("def_rd_en_count", d_pops, (144 - 12) * 480);
        end
        chk("def_first_rd_en_pos", d_first_rd, 12 * 525 + 43);
        chk("big_no_rd_en", b_pops, 0);
        chk("big_de_seen", int'(b_de_seen), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
